// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the OCXO tuning-DAC write sequencer.
// Holds the sequencer state enum, datapath widths and the unsigned clamp helper.
package dac_seq_pkg;

    localparam int DAC_W      = 16;
    localparam int SPI_BYTE_W = 8;

    localparam logic [DAC_W-1:0] DEFAULT_INIT_CODE = 16'h9E23;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SEND_MSB = 3'd2,
        WAIT_MSB = 3'd3,
        SEND_LSB = 3'd4,
        WAIT_LSB = 3'd5,
        GAP      = 3'd6
    } dac_seq_state_t;

    // Unsigned clamp of a requested code into the safe DAC window.
    function automatic logic [DAC_W-1:0] clamp_code(
        input logic [DAC_W-1:0] code,
        input logic [DAC_W-1:0] lo,
        input logic [DAC_W-1:0] hi
    );
        logic [DAC_W-1:0] result;
        result = code;
        if (code < lo) begin
            result = lo;
        end else if (code > hi) begin
            result = hi;
        end
        return result;
    endfunction

endpackage

// File: rtl/dac_slew_limiter.sv
// Combinational slew limiter: moves current toward target by at most max_step.
// Only instantiated when DAC_SLEW_LIMIT_EN is defined.
module dac_slew_limiter
    import dac_seq_pkg::*;
(
    input  logic [DAC_W-1:0] target,
    input  logic [DAC_W-1:0] current,
    input  logic [DAC_W-1:0] max_step,
    output logic [DAC_W-1:0] next
);

    logic signed [DAC_W:0] diff;
    logic signed [DAC_W:0] lim_pos;
    logic signed [DAC_W:0] lim_neg;
    logic signed [DAC_W:0] step;

    assign diff    = $signed({1'b0, target}) - $signed({1'b0, current});
    assign lim_pos = $signed({1'b0, max_step});
    assign lim_neg = -lim_pos;

    always_comb begin
        step = diff;
        if (diff > lim_pos) begin
            step = lim_pos;
        end else if (diff < lim_neg) begin
            step = lim_neg;
        end
    end

    // The limited result always lies between current and target, so a
    // modulo-2^16 add of the low bits is exact.
    assign next = current + step[DAC_W-1:0];

endmodule

// File: rtl/dac_write_sequencer.sv
// Clamps, optionally slew-limits (DAC_SLEW_LIMIT_EN), and ships DAC codes as
// two-byte MSB-first frames through the SPI master's byte handshake.
module dac_write_sequencer
    import dac_seq_pkg::*;
#(
    parameter logic [DAC_W-1:0] CODE_MIN   = 16'h0400,
    parameter logic [DAC_W-1:0] CODE_MAX   = 16'hFC00,
    parameter logic [DAC_W-1:0] INIT_CODE  = DEFAULT_INIT_CODE,
    parameter logic [DAC_W-1:0] MAX_STEP   = 16'd64,
    parameter logic [7:0]       GAP_CYCLES = 8'd50
) (
    input  logic                  clk50,
    input  logic                  reset,
    input  logic [DAC_W-1:0]      code_in,
    input  logic                  code_valid,
    output logic [SPI_BYTE_W-1:0] spi_tx_byte,
    output logic                  spi_tx_dv,
    input  logic                  spi_tx_ready,
    output logic [DAC_W-1:0]      code_written,
    output logic                  write_done,
    output logic                  busy,
    output logic [7:0]            overrun_count
);

    // Handshake: a byte is transferred in the cycle spi_tx_dv is high, and
    // spi_tx_dv only rises while spi_tx_ready is high. The cycle after a byte
    // is ignored so a ready that falls one cycle late is not taken as "done".

    dac_seq_state_t   state_q;
    dac_seq_state_t   state_d;
    logic [DAC_W-1:0] target_q;
    logic [DAC_W-1:0] frame_code;
    logic [DAC_W-1:0] next_code;
    logic             pending_new;
    logic             wait_first;
    logic             finish_frame;
    logic             gap_done;
    logic [7:0]       gap_cnt;

    if (CODE_MIN > CODE_MAX || MAX_STEP == '0) begin : g_bad_params
        $error("dac_write_sequencer: CODE_MIN above CODE_MAX or zero MAX_STEP");
    end

`ifdef DAC_SLEW_LIMIT_EN
    dac_slew_limiter u_slew (
        .target   (target_q),
        .current  (code_written),
        .max_step (MAX_STEP),
        .next     (next_code)
    );
`else
    assign next_code = target_q;
`endif

    assign gap_done = (GAP_CYCLES == 8'd0) || (gap_cnt == GAP_CYCLES - 8'd1);
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        spi_tx_dv    = 1'b0;
        spi_tx_byte  = '0;
        finish_frame = 1'b0;
        case (state_q)
            IDLE: begin
                // A same-cycle strobe launches immediately to keep latency at two cycles.
                if (code_valid || pending_new || (target_q != code_written)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SEND_MSB;
            end
            SEND_MSB: begin
                spi_tx_byte = frame_code[DAC_W-1:SPI_BYTE_W];
                if (spi_tx_ready) begin
                    spi_tx_dv = 1'b1;
                    state_d   = WAIT_MSB;
                end
            end
            WAIT_MSB: begin
                if (!wait_first && spi_tx_ready) begin
                    state_d = SEND_LSB;
                end
            end
            SEND_LSB: begin
                spi_tx_byte = frame_code[SPI_BYTE_W-1:0];
                if (spi_tx_ready) begin
                    spi_tx_dv = 1'b1;
                    state_d   = WAIT_LSB;
                end
            end
            WAIT_LSB: begin
                if (!wait_first && spi_tx_ready) begin
                    finish_frame = 1'b1;
                    state_d      = GAP;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The partial frame is abandoned the moment reset is seen.
        if (reset) begin
            spi_tx_dv   = 1'b0;
            spi_tx_byte = '0;
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q       <= IDLE;
            target_q      <= INIT_CODE;
            frame_code    <= INIT_CODE;
            code_written  <= INIT_CODE;
            pending_new   <= 1'b0;
            overrun_count <= 8'd0;
            write_done    <= 1'b0;
            wait_first    <= 1'b0;
            gap_cnt       <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_first <= spi_tx_dv;
            write_done <= finish_frame;
            gap_cnt    <= (state_q == GAP) ? gap_cnt + 8'd1 : 8'd0;

            if (code_valid) begin
                target_q <= clamp_code(code_in, CODE_MIN, CODE_MAX);
            end

            // A new request outranks the clear, so a strobe during LOAD stays pending.
            if (code_valid) begin
                pending_new <= 1'b1;
            end else if (state_q == LOAD) begin
                pending_new <= 1'b0;
            end

            if (code_valid && pending_new && (state_q != LOAD) && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end

            if (state_q == LOAD) begin
                frame_code <= next_code;
            end

            if (finish_frame) begin
                code_written <= frame_code;
            end
        end
    end

endmodule

// File: tb/tb_dac_write_sequencer.sv
// Randomized self-checking bench for dac_write_sequencer with a frame-level
// reference model; build with DAC_SLEW_LIMIT_EN defined to cover the slew path.
module tb_dac_write_sequencer;

    localparam logic [15:0] CODE_MIN   = 16'h0400;
    localparam logic [15:0] CODE_MAX   = 16'hFC00;
    localparam logic [15:0] INIT_CODE  = 16'h9E23;
    localparam logic [15:0] MAX_STEP   = 16'd64;
    localparam int          GAP_CYCLES = 50;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] code_in = '0;
    logic        code_valid = 1'b0;
    logic [7:0]  spi_tx_byte;
    logic        spi_tx_dv;
    logic        spi_tx_ready;
    logic [15:0] code_written;
    logic        write_done;
    logic        busy;
    logic [7:0]  overrun_count;

    dac_write_sequencer #(
        .CODE_MIN   (CODE_MIN),
        .CODE_MAX   (CODE_MAX),
        .INIT_CODE  (INIT_CODE),
        .MAX_STEP   (MAX_STEP),
        .GAP_CYCLES (8'(GAP_CYCLES))
    ) dut (
        .clk50         (clk50),
        .reset         (reset),
        .code_in       (code_in),
        .code_valid    (code_valid),
        .spi_tx_byte   (spi_tx_byte),
        .spi_tx_dv     (spi_tx_dv),
        .spi_tx_ready  (spi_tx_ready),
        .code_written  (code_written),
        .write_done    (write_done),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk50 = ~clk50;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- SPI master model ----------------
    // Ready stays high for one cycle after a byte, then drops for 20 cycles.
    logic spi_drop;
    int   spi_hold;
    always @(posedge clk50) begin
        if (reset) begin
            spi_tx_ready <= 1'b1;
            spi_drop     <= 1'b0;
            spi_hold     <= 0;
        end else begin
            if (spi_drop) begin
                spi_tx_ready <= 1'b0;
                spi_hold     <= 20;
                spi_drop     <= 1'b0;
            end else if (spi_hold != 0) begin
                spi_hold <= spi_hold - 1;
                if (spi_hold == 1) spi_tx_ready <= 1'b1;
            end
            if (spi_tx_dv) spi_drop <= 1'b1;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_written = INIT_CODE;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] clamp_req(input logic [15:0] c);
        if (c < CODE_MIN) return CODE_MIN;
        if (c > CODE_MAX) return CODE_MAX;
        return c;
    endfunction

    function automatic logic [15:0] step_to(input logic [15:0] cur, input logic [15:0] tgt);
`ifdef DAC_SLEW_LIMIT_EN
        int d;
        d = int'(tgt) - int'(cur);
        if (d > int'(MAX_STEP)) d = int'(MAX_STEP);
        if (d < -int'(MAX_STEP)) d = -int'(MAX_STEP);
        return 16'(int'(cur) + d);
`else
        return tgt;
`endif
    endfunction

    task automatic expect_one(input logic [15:0] req);
        m_written = step_to(m_written, clamp_req(req));
        exp_q.push_back(m_written);
    endtask

    // At least one frame (a refresh when already there), then follow-ups until settled.
    task automatic expect_settle(input logic [15:0] req);
        expect_one(req);
        while (m_written != clamp_req(req)) expect_one(req);
    endtask

    function automatic logic [15:0] rand_code();
        int r;
`ifdef DAC_SLEW_LIMIT_EN
        r = int'(m_written) + int'($urandom_range(0, 400)) - 200;
        if (r < 0) r = 0;
        if (r > 65535) r = 65535;
        if ($urandom_range(0, 3) == 0) r = int'(m_written);
`else
        case ($urandom_range(0, 3))
            0:       r = int'(m_written);
            1:       r = int'($urandom_range(0, 32'h03FF));
            2:       r = int'($urandom_range(32'hFC01, 32'hFFFF));
            default: r = int'($urandom_range(0, 32'hFFFF));
        endcase
`endif
        return 16'(r);
    endfunction

    // ---------------- frame monitor / scoreboard ----------------
    int          cyc = 0;
    int          last_wd_cyc = -1;
    int          wd_seen = 0;
    bit          mon_phase = 1'b0;
    logic [7:0]  mon_msb = '0;
    logic [7:0]  mon_lsb = '0;
    bit          mon_stream = 1'b0;
    logic [15:0] mon_stream_code = '0;
    logic [15:0] exp_frame;

    always @(posedge clk50) cyc++;

    always @(negedge clk50) begin
        if (reset) begin
            mon_phase   = 1'b0;
            last_wd_cyc = -1;
        end else begin
            if (spi_tx_dv) begin
                check("dv_while_ready", 32'(spi_tx_ready), 1);
                if (!mon_phase) begin
                    if (last_wd_cyc >= 0)
                        check("frame_gap", 32'((cyc - last_wd_cyc) >= GAP_CYCLES + 2), 1);
                    mon_msb   = spi_tx_byte;
                    mon_phase = 1'b1;
                end else begin
                    mon_lsb   = spi_tx_byte;
                    mon_phase = 1'b0;
                end
            end
            if (write_done) begin
                wd_seen++;
                last_wd_cyc = cyc;
                if (mon_stream) begin
                    check("stream_frame", 32'({mon_msb, mon_lsb}), 32'(mon_stream_code));
                    check("stream_written", 32'(code_written), 32'(mon_stream_code));
                end else begin
                    check("frame_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        exp_frame = exp_q.pop_front();
                        check("frame_bytes", 32'({mon_msb, mon_lsb}), 32'(exp_frame));
                        check("frame_written", 32'(code_written), 32'(exp_frame));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic pulse_code(input logic [15:0] c);
        code_in    = c;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_settle"}, 32'(n < budget), 1);
    endtask

    task automatic wait_dv(input string tag, input int budget);
        int n = 0;
        while (!spi_tx_dv && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_dv_seen"}, 32'(n < budget), 1);
    endtask

    task automatic run_code(input string tag, input logic [15:0] c);
        expect_settle(c);
        pulse_code(c);
        wait_quiet(tag, 3000);
        check({tag, "_written"}, 32'(code_written), 32'(m_written));
    endtask

    // ---------------- test sequence ----------------
    logic [15:0] c_x;
    logic [15:0] c_y;
    int          wd_before;

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        check("rst_written", 32'(code_written), 32'h9E23);
        check("rst_busy", 32'(busy), 0);
        check("rst_dv", 32'(spi_tx_dv), 0);
        check("rst_byte", 32'(spi_tx_byte), 0);
        check("rst_done", 32'(write_done), 0);
        check("rst_overrun", 32'(overrun_count), 0);
        reset = 1'b0;
        m_written = INIT_CODE;
        repeat (2) tick();

        // First request: two-cycle latency to the MSB byte.
        expect_settle(16'hA000);
        pulse_code(16'hA000);
        check("lat_n1_dv", 32'(spi_tx_dv), 0);
        check("lat_n1_busy", 32'(busy), 1);
        tick();
        check("lat_n2_dv", 32'(spi_tx_dv), 1);
        check("lat_n2_byte", 32'(spi_tx_byte), 32'(exp_q[0][15:8]));
        wait_quiet("a000", 3000);
`ifndef DAC_SLEW_LIMIT_EN
        check("a000_written", 32'(code_written), 32'hA000);
        run_code("clamp_hi", 16'hFFFF);
        check("clamp_hi_const", 32'(code_written), 32'hFC00);
        run_code("clamp_lo", 16'h0000);
        check("clamp_lo_const", 32'(code_written), 32'h0400);
`else
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_written = INIT_CODE;
        tick();
        run_code("slew", 16'h9F23);
        check("slew_const", 32'(code_written), 32'h9F23);
`endif

        // Three strobes inside one frame: one overrun, last request wins.
        expect_one(16'hA100);
        pulse_code(16'hA100);
        wait_dv("ovr", 20);
        pulse_code(16'hA200);
        pulse_code(16'hA300);
        expect_settle(16'hA300);
        wait_quiet("ovr", 3000);
        check("ovr_count", 32'(overrun_count), 1);
        check("ovr_written", 32'(code_written), 32'hA300);

        // Strobe landing on the LOAD cycle: stays pending, no overrun.
        c_x = rand_code();
        c_y = rand_code();
        expect_one(c_x);
        pulse_code(c_x);
        pulse_code(c_y);
        expect_settle(c_y);
        wait_quiet("load_hit", 3000);
        check("load_hit_overrun", 32'(overrun_count), 1);
        check("load_hit_written", 32'(code_written), 32'(clamp_req(c_y)));

        // Randomized requests, each allowed to settle.
        for (int i = 0; i < 8; i++) begin
            run_code("rand", rand_code());
        end

        // Continuous strobes saturate the overrun counter.
        mon_stream      = 1'b1;
        mon_stream_code = m_written;
        code_in    = m_written;
        code_valid = 1'b1;
        repeat (300) tick();
        code_valid = 1'b0;
        repeat (250) tick();
        check("sat_busy", 32'(busy), 0);
        check("sat_overrun", 32'(overrun_count), 255);
        check("sat_written", 32'(code_written), 32'(mon_stream_code));
        mon_stream = 1'b0;

        // Reset while waiting on the MSB: frame discarded, no completion.
        c_x = rand_code();
        expect_one(c_x);
        pulse_code(c_x);
        wait_dv("rst_mid", 20);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        m_written = INIT_CODE;
        wd_before = wd_seen;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_dv", 32'(spi_tx_dv), 0);
        check("rst_mid_written", 32'(code_written), 32'h9E23);
        check("rst_mid_overrun", 32'(overrun_count), 0);
        check("rst_mid_done", 32'(write_done), 0);
        repeat (120) tick();
        check("rst_mid_no_done", 32'(wd_seen - wd_before), 0);

        // Normal operation resumes after the mid-frame reset.
        run_code("post_rst", rand_code());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dac_write_sequencer.md
# dac_write_sequencer

Sits downstream of the DPLL loop filter, between the corrected DAC code and the SPI master that drives the OCXO tuning DAC. Accepts a new 16-bit code as a single-cycle strobe, clamps it to a safe range, optionally slew-limits it, and sends each result as a two-byte, MSB-first frame through the SPI master's byte handshake. It replaces the ad hoc count-based byte timing in the top level. It also reports the code actually written, so the UART monitor shows true DAC state.

## Interface
Parameters:
- CODE_MIN, 16'h0400, lowest code ever written
- CODE_MAX, 16'hFC00, highest code ever written
- INIT_CODE, 16'h9E23, value of code_written out of reset
- MAX_STEP, 16'd64, largest per-frame code change when slew limiting is enabled
- GAP_CYCLES, 8'd50, idle clk50 cycles enforced after every frame (0 = no gap)

Ports:
- clk50  in  1  system clock. One clock only.
- reset  in  1  synchronous, active-high
- code_in  in  16  requested DAC code, unsigned
- code_valid  in  1  single-cycle strobe, sampled with code_in
- spi_tx_byte  out  8  byte to SPI master
- spi_tx_dv  out  1  one-cycle byte-valid to SPI master
- spi_tx_ready  in  1  SPI master ready
- code_written  out  16  last code fully transmitted
- write_done  out  1  one-cycle pulse when a frame completes
- busy  out  1  high in any state other than IDLE
- overrun_count  out  8  saturating count of superseded requests

## Operation
- Target register: on code_valid, target <= clamp(code_in, CODE_MIN, CODE_MAX). Comparison is unsigned. The most recent request always wins.
- pending_new flag:
  - Set by code_valid.
  - Cleared when a frame is loaded.
  - code_valid while pending_new=1 increments overrun_count, saturating at 255.
- Next code:
  - Without slew limiting, next = target.
  - With slew limiting, d = target - code_written as signed 17-bit. next = code_written + clamp(d, -MAX_STEP, +MAX_STEP).
- States:
  - IDLE: if pending_new or target != code_written, go to LOAD.
  - LOAD: frame_code <= next, clear pending_new, go to SEND_MSB.
  - SEND_MSB: spi_tx_byte = frame_code[15:8], spi_tx_dv = 1 for exactly one cycle, go to WAIT_MSB.
  - WAIT_MSB: ignore spi_tx_ready on the first cycle. Then wait for spi_tx_ready = 1 and go to SEND_LSB.
  - SEND_LSB and WAIT_LSB: same as the MSB pair, using frame_code[7:0].
  - On leaving WAIT_LSB: code_written <= frame_code, pulse write_done, go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE. IDLE re-launches at once if target != code_written, which is how slew follow-up frames are issued.
- spi_tx_dv is never asserted while spi_tx_ready = 0.
- Reset mid-frame: return to IDLE at once. spi_tx_dv = 0, and the partial frame is discarded. The SPI master shares this reset.

## Timing
- Reset values:
  - spi_tx_byte = 0, spi_tx_dv = 0, write_done = 0, busy = 0, overrun_count = 0
  - code_written = INIT_CODE, target = INIT_CODE, pending_new = 0
- Request-to-SPI latency: code_valid at cycle N in IDLE. Cycle N+1 is IDLE→LOAD. spi_tx_dv for the MSB is high in cycle N+2.
- write_done is high in the cycle after the second spi_tx_ready rise, concurrent with code_written updating.
- Back-to-back frames are separated by at least GAP_CYCLES + 2 cycles.
- code_valid in the same cycle as LOAD: LOAD uses the old target, and the new request stays pending. No overrun is counted, because pending_new was cleared in that cycle.
- A code_valid with a clamped value equal to code_written, with pending_new = 0, still produces one frame (refresh).

## Configuration
- DAC_SLEW_LIMIT_EN defined: MAX_STEP limiting is active, and a large target produces a series of frames.
- Not defined: the limiter logic is absent and next = target. MAX_STEP is unused.

## Structure
- Package dac_seq_pkg holds:
  - the state enum (IDLE, LOAD, SEND_MSB, WAIT_MSB, SEND_LSB, WAIT_LSB, GAP)
  - DAC_W = 16 and SPI_BYTE_W = 8
  - default INIT_CODE
- Sub-module dac_slew_limiter: combinational. Inputs are target, current and max_step; output is next. It is instantiated only under DAC_SLEW_LIMIT_EN.

## Test plan
- Bench SPI model: ready drops 1 cycle after dv and returns 20 cycles later.
- After reset, code_written = 16'h9E23 and busy = 0. A single code_valid with 16'hA000, slew disabled, produces MSB 8'hA0 then LSB 8'h00, then write_done, and code_written = 16'hA000.
- code_in = 16'hFFFF gives a written value of 16'hFC00. code_in = 16'h0000 gives 16'h0400.
- Slew enabled, MAX_STEP = 64, code_written = 16'h9E23, request 16'h9F23: four frames 9E63, 9EA3, 9EE3, 9F23, each separated by ≥ 52 cycles.
- Three code_valid strobes during one frame (A100, A200, A300): overrun_count = 1, and the next frame writes 16'hA300.
- Assert reset while in WAIT_MSB: next cycle the state is IDLE, spi_tx_dv = 0, code_written = INIT_CODE, and no write_done pulse occurs.
